// File: rtl/flags_branch_unit.sv
// -----------------------------------------------------------------------------
// flags_branch_unit
//
// Consumer side of the ALU flag interface in the nonpipelined LEGv8 core.
// Holds the architectural NZCV register and the program counter. It evaluates
// B, B.cond, CBZ, CBNZ and BR, and it computes the next PC. The pc output drives
// instruction memory.
//
// Ports
//   clk           in   1     system clock; all state updates on the rising edge
//   reset_n       in   1     synchronous active-low reset
//   advance       in   1     instruction retires this cycle (qualifies updates)
//   alu_zero      in   1     ALU zero flag of the current instruction
//   alu_negative  in   1     ALU negative flag
//   alu_carry     in   1     ALU carry flag
//   alu_overflow  in   1     ALU overflow flag
//   flag_write    in   1     current instruction sets flags
//   branch_type   in   3     0 NONE, 1 B, 2 BCOND, 3 CBZ, 4 CBNZ, 5 BR
//                            (6 and 7 are reserved and behave as NONE)
//   cond          in   4     B.cond condition code
//   imm_offset    in   WORD  sign-extended word offset (B, B.cond, CBZ, CBNZ)
//   br_target     in   WORD  register value used by BR
//   pc            out  WORD  current program counter (registered)
//   nzcv          out  4     registered flags {N,Z,C,V}
//   taken         out  1     combinational: current instruction redirects PC
//
// Handshake: there is no valid/ready pair. advance is a single-cycle
// qualifier. pc and nzcv update only on a rising edge where advance=1 and
// reset_n=1. While advance=0 every other input is ignored for state purposes.
// taken is still driven combinationally from the current inputs.
// -----------------------------------------------------------------------------
module flags_branch_unit #(
  parameter int              WORD     = 64,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            advance,
  input  logic            alu_zero,
  input  logic            alu_negative,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  input  logic            flag_write,
  input  logic [2:0]      branch_type,
  input  logic [3:0]      cond,
  input  logic [WORD-1:0] imm_offset,
  input  logic [WORD-1:0] br_target,
  output logic [WORD-1:0] pc,
  output logic [3:0]      nzcv,
  output logic            taken
);

  localparam logic [2:0] BT_NONE  = 3'd0;
  localparam logic [2:0] BT_B     = 3'd1;
  localparam logic [2:0] BT_BCOND = 3'd2;
  localparam logic [2:0] BT_CBZ   = 3'd3;
  localparam logic [2:0] BT_CBNZ  = 3'd4;
  localparam logic [2:0] BT_BR    = 3'd5;

  localparam logic [WORD-1:0] FOUR     = {{(WORD-3){1'b0}}, 3'd4};
  localparam logic [WORD-1:0] LOW2_MSK = {{(WORD-2){1'b0}}, 2'b11};

  logic            flag_n, flag_z, flag_c, flag_v;
  logic            cond_met;
  logic [WORD-1:0] pc_plus4;
  logic [WORD-1:0] pc_rel;
  logic [WORD-1:0] next_pc;

  // B.cond always looks at the registered flags. A flag-setting B.cond
  // therefore branches on the previous instruction's result.
  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

  // Odd codes are the complement of the preceding even code, except for
  // 15 (NV), which behaves like AL.
  always_comb begin
    cond_met = 1'b1;
    case (cond[3:1])
      3'd0: cond_met = flag_z;
      3'd1: cond_met = flag_c;
      3'd2: cond_met = flag_n;
      3'd3: cond_met = flag_v;
      3'd4: cond_met = flag_c & ~flag_z;
      3'd5: cond_met = (flag_n == flag_v);
      3'd6: cond_met = ~flag_z & (flag_n == flag_v);
      default: cond_met = 1'b1;
    endcase
    if (cond[0] && (cond[3:1] != 3'd7)) begin
      cond_met = ~cond_met;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (branch_type)
      BT_B:     taken = 1'b1;
      BT_BCOND: taken = cond_met;
      BT_CBZ:   taken = alu_zero;
      BT_CBNZ:  taken = ~alu_zero;
      BT_BR:    taken = 1'b1;
      BT_NONE:  taken = 1'b0;
      default:  taken = 1'b0;
    endcase
  end

  // Word offsets are scaled to bytes. All sums wrap silently modulo 2^WORD.
  assign pc_plus4 = pc + FOUR;
  assign pc_rel   = pc + (imm_offset << 2);

  always_comb begin
    next_pc = pc_plus4;
    if (taken) begin
      if (branch_type == BT_BR) begin
        next_pc = br_target & ~LOW2_MSK;
      end else begin
        next_pc = pc_rel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc   <= RESET_PC;
      nzcv <= 4'b0000;
    end else if (advance) begin
      pc <= next_pc;
      if (flag_write) begin
        nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
      end
    end
  end

endmodule
